// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging byte frames from NUM_REQ requesters into one registered UART TX stream.
// Optional stall abort is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter value");
  end

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] sel_id;
  logic           sel_vld;
  logic           can_load;
  logic           accept;
  logic           abort;
  logic [7:0]     req_byte [NUM_REQ];

  // Rotating priority: search starts just after the previous winner.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    sel_vld = 1'b0;
    sel_id  = '0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last_grant) + k) % NUM_REQ;
      idx_w = IDW'(idx);
      if (!sel_vld && req_valid[idx_w]) begin
        sel_vld = 1'b1;
        sel_id  = idx_w;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  assign busy     = (state == XFER);
  assign can_load = !tx_valid || tx_ready;
  assign accept   = busy && can_load && req_valid[grant_id];

  always_comb begin
    req_ready = '0;
    if (busy && can_load) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sel_vld) state_nxt = XFER;
      XFER: if ((accept && req_last[grant_id]) || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
      tx_data    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      if (state == IDLE && sel_vld) begin
        grant_id   <= sel_id;
        last_grant <= sel_id;
      end
      // A new byte may replace the one leaving in the same cycle.
      if (accept) begin
        tx_data  <= req_byte[grant_id];
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] stall_cnt;

  assign abort         = busy && !req_valid[grant_id] && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_pulse = abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!busy || accept || abort) begin
      stall_cnt <= '0;
    end else if (!req_valid[grant_id]) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign abort         = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, timeout 8 when enabled).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_pulse;

  int errors = 0;
  int checks = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .timeout_pulse(timeout_pulse)
  );

  // Bytes handed to the transmitter, captured mid-cycle before the accepting edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid[i]       = v;
    req_last[i]        = l;
    req_data[8*i +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    txq.delete();
  endtask

  task automatic test_reset();
    step();
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout_pulse); end
    step();
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rst_held: busy %b ready %b want 0 0000", busy, req_ready); end
  endtask

  task automatic test_single_frame();
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h11);
    step();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: busy %b id %0d want 1 0", busy, grant_id); end
    checks++; if (req_ready !== 4'b0001 || tx_valid !== 1'b0) begin errors++; $display("FAIL single_ready: ready %b txv %b want 0001 0", req_ready, tx_valid); end
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL single_b0: txv %b data %h want 1 11", tx_valid, tx_data); end
    set_req(0, 1'b1, 1'b0, 8'h22);
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin errors++; $display("FAIL single_b1: txv %b data %h want 1 22", tx_valid, tx_data); end
    set_req(0, 1'b1, 1'b1, 8'h33);
    step();
    checks++; if (tx_data !== 8'h33 || busy !== 1'b0) begin errors++; $display("FAIL single_b2: data %h busy %b want 33 0", tx_data, busy); end
    set_req(0, 1'b0, 1'b0, 8'h00);
    step();
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end: txv %b busy %b want 0 0", tx_valid, busy); end
    checks++;
    if (txq.size() != 3 || txq[0] !== 8'h11 || txq[1] !== 8'h22 || txq[2] !== 8'h33) begin
      errors++; $display("FAIL single_stream: got %0d bytes want 11 22 33", txq.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 8'h40 + 8'(i));
    for (int g = 0; g < 5; g++) begin
      step();
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'(g % 4)) begin
        errors++; $display("FAIL rr_grant%0d: busy %b id %0d want 1 %0d", g, busy, grant_id, g % 4);
      end
      step();
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h40 + 8'(g % 4)) begin
        errors++; $display("FAIL rr_idle%0d: busy %b txv %b data %h want 0 1 %h", g, busy, tx_valid, tx_data, 8'h40 + 8'(g % 4));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    set_req(2, 1'b1, 1'b0, 8'hA5);
    step();
    checks++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) begin errors++; $display("FAIL stall_grant: id %0d ready %b want 2 0100", grant_id, req_ready); end
    step();
    set_req(2, 1'b1, 1'b1, 8'h5A);
    tx_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000 || tx_data !== 8'hA5) begin errors++; $display("FAIL stall_full1: ready %b data %h want 0000 a5", req_ready, tx_data); end
    step();
    checks++; if (req_ready !== 4'b0000 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL stall_full2: ready %b txv %b data %h want 0000 1 a5", req_ready, tx_valid, tx_data); end
    step();
    tx_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_resume: ready %b want 0100", req_ready); end
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A || busy !== 1'b0) begin errors++; $display("FAIL stall_b1: txv %b data %h busy %b want 1 5a 0", tx_valid, tx_data, busy); end
    set_req(2, 1'b0, 1'b0, 8'h00);
    step();
    step();
    checks++;
    if (txq.size() != 2 || txq[0] !== 8'hA5 || txq[1] !== 8'h5A) begin
      errors++; $display("FAIL stall_stream: got %0d bytes want a5 5a", txq.size());
    end
  endtask

  task automatic test_no_interleave();
    do_reset();
    set_req(1, 1'b1, 1'b0, 8'h10);
    set_req(3, 1'b1, 1'b1, 8'hEE);
    step();
    checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL nil_c1: id %0d ready %b want 1 0010", grant_id, req_ready); end
    req_valid[3] = 1'b0;
    step();
    checks++; if (tx_data !== 8'h10 || req_ready !== 4'b0010) begin errors++; $display("FAIL nil_c2: data %h ready %b want 10 0010", tx_data, req_ready); end
    set_req(1, 1'b1, 1'b0, 8'h11);
    req_valid[3] = 1'b1;
    step();
    checks++; if (tx_data !== 8'h11 || req_ready !== 4'b0010) begin errors++; $display("FAIL nil_c3: data %h ready %b want 11 0010", tx_data, req_ready); end
    set_req(1, 1'b1, 1'b1, 8'h12);
    req_valid[3] = 1'b0;
    step();
    checks++; if (tx_data !== 8'h12 || busy !== 1'b0) begin errors++; $display("FAIL nil_c4: data %h busy %b want 12 0", tx_data, busy); end
    set_req(1, 1'b0, 1'b0, 8'h00);
    req_valid[3] = 1'b1;
    step();
    checks++; if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin errors++; $display("FAIL nil_g3: id %0d ready %b want 3 1000", grant_id, req_ready); end
    step();
    req_valid[3] = 1'b0;
    step();
    step();
    checks++;
    if (txq.size() != 4 || txq[0] !== 8'h10 || txq[1] !== 8'h11 || txq[2] !== 8'h12 || txq[3] !== 8'hEE) begin
      errors++; $display("FAIL nil_stream: got %0d bytes want 10 11 12 ee", txq.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h77);
    set_req(1, 1'b1, 1'b1, 8'h99);
    step();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL to_grant: id %0d want 0", grant_id); end
    step();
    req_valid[0] = 1'b0;
    #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 2; k <= 8; k++) begin
      checks++;
      if (timeout_pulse !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_wait%0d: pulse %b busy %b want 0 1", k, timeout_pulse, busy); end
      step();
    end
    checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout_pulse); end
    step();
    checks++; if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_idle: busy %b pulse %b want 0 0", busy, timeout_pulse); end
    step();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL to_regrant: busy %b id %0d want 1 1", busy, grant_id); end
`else
    for (int k = 2; k <= 12; k++) begin
      checks++;
      if (timeout_pulse !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0) begin
        errors++; $display("FAIL to_hold%0d: pulse %b busy %b id %0d want 0 1 0", k, timeout_pulse, busy, grant_id);
      end
      step();
    end
    set_req(0, 1'b1, 1'b1, 8'h78);
    step();
    checks++; if (busy !== 1'b0 || tx_data !== 8'h78) begin errors++; $display("FAIL to_last: busy %b data %h want 0 78", busy, tx_data); end
    req_valid[0] = 1'b0;
    step();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL to_next: busy %b id %0d want 1 1", busy, grant_id); end
`endif
    req_valid = '0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h01);
    step();
    step();
    set_req(0, 1'b1, 1'b0, 8'h02);
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h02 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: txv %b data %h busy %b want 1 02 1", tx_valid, tx_data, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst: txv %b id %0d busy %b want 0 0 0", tx_valid, grant_id, busy); end
    checks++; if (tx_data !== 8'h00 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_data: data %h ready %b want 00 0000", tx_data, req_ready); end
    set_req(1, 1'b1, 1'b1, 8'h55);
    step();
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_first: busy %b id %0d want 1 0", busy, grant_id); end
    req_valid = '0;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    step();
    rst_n = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back_stall();
    test_no_interleave();
    test_timeout();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: requester stall limit in cycles, minimum 2; used only under UART_TX_ARB_TIMEOUT_EN.
REQ-003 Localparam IDW = $clog2(NUM_REQ).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_data  input  NUM_REQ*8  byte from requester i in bits [8*i+:8].
REQ-007 req_valid  input  NUM_REQ  requester i byte valid.
REQ-008 req_last  input  NUM_REQ  requester i byte is the final byte of its frame.
REQ-009 req_ready  output  NUM_REQ  requester i byte accepted when valid and ready are both high.
REQ-010 tx_data  output  8  byte to UART transmitter, registered.
REQ-011 tx_valid  output  1  tx_data valid, registered.
REQ-012 tx_ready  input  1  transmitter accepts tx_data.
REQ-013 grant_id  output  IDW  index of the currently granted requester.
REQ-014 busy  output  1  high while in XFER.
REQ-015 timeout_pulse  output  1  one-cycle pulse on frame abort.

Function
REQ-016 States SHALL be IDLE and XFER; busy = (state == XFER).
REQ-017 In IDLE with any req_valid high, the block SHALL select the first requester with req_valid high, searching from last_grant+1 upward modulo NUM_REQ, register it into grant_id and last_grant, and enter XFER on the next cycle.
REQ-018 In IDLE with no req_valid high, the block SHALL stay in IDLE with grant_id unchanged.
REQ-019 req_ready[i] SHALL be high only when busy, grant_id == i, and (!tx_valid || tx_ready); all other bits SHALL be 0.
REQ-020 On accept, tx_data SHALL load req_data[grant_id] and tx_valid SHALL be set at the next edge.
REQ-021 When tx_valid && tx_ready and no accept occurs in the same cycle, tx_valid SHALL clear; an accept in the same cycle keeps tx_valid high with the new byte.
REQ-022 Latency: req_valid rising in IDLE at cycle N gives req_ready at N+1 and tx_valid with the first byte at N+2, provided the output register is empty.
REQ-023 Accepting a byte with req_last high SHALL return the block to IDLE at the next edge; frames are never interleaved.
REQ-024 Back-to-back frames SHALL incur exactly one IDLE cycle between the last accept and the next grant.
REQ-025 Sole requester: the block SHALL re-grant that requester after one IDLE cycle.
REQ-026 req_valid, req_data and req_last from non-granted requesters SHALL be ignored.
REQ-027 tx_ready held low SHALL stall acceptance indefinitely without losing or duplicating bytes.

Reset
REQ-028 While rst_n is low, the block SHALL hold: state = IDLE, tx_valid = 0, tx_data = 0, grant_id = 0, last_grant = NUM_REQ-1 (requester 0 wins first), req_ready = 0, busy = 0, timeout_pulse = 0, timeout counter = 0.
REQ-029 Reset asserted mid-frame SHALL discard the byte held in the output register and the remainder of the frame.

Configuration
REQ-030 With macro UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL increment each XFER cycle in which req_valid[grant_id] is low and SHALL clear on accept or on leaving XFER.
REQ-031 With UART_TX_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1, the block SHALL return to IDLE, assert timeout_pulse for one cycle, and leave any byte already in the output register to drain normally.
REQ-032 Without UART_TX_ARB_TIMEOUT_EN, no counter SHALL be built, timeout_pulse SHALL be tied to 0, and a grant SHALL be held until an accept with req_last high.

Verification
REQ-033 Requester 0 only, 3-byte frame 0x11,0x22,0x33 (last on 0x33), tx_ready=1 -> tx shows 0x11,0x22,0x33 starting 2 cycles after req_valid; busy drops after the last accept.
REQ-034 All 4 requesters each hold a 1-byte frame after reset -> grant order 0,1,2,3,0; exactly one IDLE cycle between grants.
REQ-035 Requester 2 frame of 0xA5,0x5A with tx_ready toggling 1,0,0,1 per cycle -> exactly 0xA5 then 0x5A on tx, no duplicates; req_ready low while the output register is full and tx_ready is low.
REQ-036 Requesters 1 and 3 active; requester 1 mid-frame; requester 3 toggles valid -> no requester-3 byte appears until requester 1 accepts its last byte.
REQ-037 Macro defined, TIMEOUT_CYCLES=8; requester 0 sends 1 byte without last, then holds valid low -> timeout_pulse 8 cycles after the accept, then IDLE, and requester 1 is granted if requesting; macro undefined -> grant held and timeout_pulse stays 0.
REQ-038 rst_n pulsed low during the second byte of a 4-byte frame -> tx_valid=0 and grant_id=0 immediately; after release, requester 0 wins first.
